// File: rtl/sys_defs.sv
// Shared types and widths for the off-chip memory read-port arbiter.
// MEM_BANDWIDTH (bytes per beat) is a global define; the default below applies only if nothing else set it.
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 8
`endif

package sys_defs;

    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_BURST_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } MEM_ARB_STATE;

    typedef enum logic {
        REQ_DEC,
        REQ_GB
    } MEM_REQUESTER;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]  addr;
        logic [MEM_BURST_W-1:0] burst_len;
    } MEM_REQ_PACKET;

endpackage

// File: rtl/mem_rr_arbiter2.sv
// Two-way round-robin pick between the decompressor (bit 0) and the global buffer (bit 1).
// Purely combinational; the caller registers the result.
module mem_rr_arbiter2
    import sys_defs::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_GB) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory read port between the decompressor and the global buffer, one burst at a time.
// Optional build macro MEM_ARB_PERF_CNT_EN adds saturating beat and ack-stall counters.
module mem_port_arbiter
    import sys_defs::*;
#(
    parameter int DATA_W  = `MEM_BANDWIDTH*8,
    parameter int BURST_W = MEM_BURST_W,
    parameter int ADDR_W  = MEM_ADDR_W
)(
    input  logic               clk,
    input  logic               rst,

    input  logic               dec_req,
    input  logic [ADDR_W-1:0]  dec_addr,
    input  logic [BURST_W-1:0] dec_burst_len,
    output logic               dec_grant,
    output logic [DATA_W-1:0]  dec_data,
    output logic               dec_data_valid,
    output logic               dec_done,

    input  logic               gb_req,
    input  logic [ADDR_W-1:0]  gb_addr,
    input  logic [BURST_W-1:0] gb_burst_len,
    output logic               gb_grant,
    output logic [DATA_W-1:0]  gb_data,
    output logic               gb_data_valid,
    output logic               gb_done,

    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BURST_W-1:0] mem_burst_len,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               mem_data_valid,

    output logic               proto_err
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_dec_beats,
    output logic [31:0]        perf_gb_beats,
    output logic [31:0]        perf_ack_stall
`endif
);

    MEM_ARB_STATE     state;
    MEM_REQUESTER     owner;
    MEM_REQUESTER     last_grant;
    MEM_REQ_PACKET    pkt;
    logic [BURST_W:0] beat_cnt;
    logic [BURST_W:0] beat_next;
    logic [BURST_W:0] beat_target;
    logic [1:0]       arb_grant;
    logic             beat_take;
    logic             last_beat;

    mem_rr_arbiter2 u_rr (
        .req        ({gb_req, dec_req}),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    assign mem_addr      = pkt.addr;
    assign mem_burst_len = pkt.burst_len;

    // A zero length field means a full 2^BURST_W burst; the extra counter bit holds that value.
    assign beat_target = (pkt.burst_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, pkt.burst_len};
    assign beat_take   = mem_data_valid && ((state == XFER) || (state == REQ && mem_ack));
    assign beat_next   = beat_cnt + (BURST_W+1)'(1);
    assign last_beat   = beat_take && (beat_next == beat_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= REQ_DEC;
            last_grant     <= REQ_GB;
            pkt            <= '0;
            beat_cnt       <= '0;
            mem_req        <= 1'b0;
            dec_grant      <= 1'b0;
            gb_grant       <= 1'b0;
            dec_data       <= '0;
            gb_data        <= '0;
            dec_data_valid <= 1'b0;
            gb_data_valid  <= 1'b0;
            dec_done       <= 1'b0;
            gb_done        <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            dec_data_valid <= 1'b0;
            gb_data_valid  <= 1'b0;
            dec_done       <= 1'b0;
            gb_done        <= 1'b0;

            // Beats that arrive when no transfer is open are dropped and flagged.
            if (mem_data_valid && !beat_take) begin
                proto_err <= 1'b1;
            end

            if (beat_take) begin
                beat_cnt <= beat_next;
                if (owner == REQ_DEC) begin
                    dec_data       <= mem_data;
                    dec_data_valid <= 1'b1;
                end else begin
                    gb_data        <= mem_data;
                    gb_data_valid  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (arb_grant != 2'b00) begin
                        if (arb_grant[0]) begin
                            owner         <= REQ_DEC;
                            pkt.addr      <= dec_addr;
                            pkt.burst_len <= dec_burst_len;
                        end else begin
                            owner         <= REQ_GB;
                            pkt.addr      <= gb_addr;
                            pkt.burst_len <= gb_burst_len;
                        end
                        dec_grant <= arb_grant[0];
                        gb_grant  <= arb_grant[1];
                        mem_req   <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                end
                default: state <= IDLE;
            endcase

            // Completion overrides the state step above, including a 1-beat burst finishing on the ack cycle.
            if (last_beat) begin
                state      <= IDLE;
                beat_cnt   <= '0;
                dec_grant  <= 1'b0;
                gb_grant   <= 1'b0;
                last_grant <= owner;
                if (owner == REQ_DEC) begin
                    dec_done <= 1'b1;
                end else begin
                    gb_done  <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dec_beats <= '0;
            perf_gb_beats  <= '0;
            perf_ack_stall <= '0;
        end else begin
            if (beat_take && owner == REQ_DEC && perf_dec_beats != '1) begin
                perf_dec_beats <= perf_dec_beats + 32'd1;
            end
            if (beat_take && owner == REQ_GB && perf_gb_beats != '1) begin
                perf_gb_beats <= perf_gb_beats + 32'd1;
            end
            if (state == REQ && perf_ack_stall != '1) begin
                perf_ack_stall <= perf_ack_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory read port between the decompressor (weight/activation stream) and the global buffer (direct fills).
- Round-robin arbitration at burst granularity; one transaction in flight at a time.
- Drives mem_req, counts returned beats and routes registered read data to the granted requester.
- Sits between both requesters and the memory interface model used by the top-level benches.

Parameters:
- DATA_W, `MEM_BANDWIDTH*8: read data width in bits.
- BURST_W, 6: burst length field width; 0 encodes 2^BURST_W beats.
- ADDR_W, 32: request address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- dec_req  in  1  decompressor request, level.
- dec_addr  in  ADDR_W  decompressor start address.
- dec_burst_len  in  BURST_W  decompressor beat count.
- dec_grant  out  1  decompressor owns port.
- dec_data  out  DATA_W  registered read data.
- dec_data_valid  out  1  beat strobe to decompressor.
- dec_done  out  1  one-cycle pulse, burst complete.
- gb_req, gb_addr, gb_burst_len, gb_grant, gb_data, gb_data_valid, gb_done: same as dec_*, for the global buffer.
- mem_req  out  1  request to memory, held until acked.
- mem_addr  out  ADDR_W  latched address.
- mem_burst_len  out  BURST_W  latched length.
- mem_ack  in  1  memory accepted request.
- mem_data  in  DATA_W  read data.
- mem_data_valid  in  1  read beat strobe.
- proto_err  out  1  sticky: mem_data_valid outside a transfer.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, beat counter 0, last_grant=GB, so the first tie goes to DEC.
- States: IDLE -> REQ -> XFER -> IDLE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On grant: latch addr and burst_len, set *_grant and mem_req, go to REQ.
  - Arbitration is registered: req at cycle t gives mem_req at t+1.
- REQ:
  - mem_req, mem_addr and mem_burst_len are held stable until mem_ack.
  - On mem_ack, drop mem_req and go to XFER.
  - A mem_data_valid in the same cycle as mem_ack counts as beat 1.
- XFER:
  - Each mem_data_valid increments the beat counter.
  - Data is registered and routed only to the granted requester: beat at t gives *_data_valid at t+1.
  - The non-granted *_data_valid stays 0; its *_data holds its previous value.
- Completion: the beat that reaches the latched length returns the block to IDLE at t+1.
  - *_done pulses at t+1, together with the last *_data_valid.
  - *_grant deasserts at t+1 and last_grant is updated.
- Re-arbitration happens in that IDLE cycle, so there is at least one bubble between bursts.
- A requester dropping req mid-burst does not abort; the burst completes and done still pulses.
- burst_len=0 means 64 beats at the default BURST_W. The counter is BURST_W+1 bits, so there is no wrap hazard.
- mem_ack outside REQ is ignored.
- mem_data_valid in IDLE or REQ-without-ack sets proto_err (sticky until rst) and the data is dropped.
- Requesters must hold addr and burst_len only until grant.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN defined: adds 32-bit saturating outputs perf_dec_beats, perf_gb_beats and perf_ack_stall (cycles spent in REQ). All reset to 0.
- Macro undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- sys_defs package holds:
  - MEM_ARB_STATE enum {IDLE, REQ, XFER};
  - MEM_REQUESTER enum {REQ_DEC, REQ_GB};
  - MEM_REQ_PACKET struct {addr, burst_len}.
- `MEM_BANDWIDTH stays in the global defines.
- One sub-module, mem_rr_arbiter2: 2-way round-robin, with inputs req[1:0] and last_grant, output grant one-hot, purely combinational. The top block owns the FSM, counter, latches and data registers.

Test Plan:
- Single decompressor burst: dec_req, dec_addr=0x100, len=4, mem_ack 3 cycles after mem_req, 4 valid beats -> 4 dec_data_valid with matching data one cycle late, dec_done with beat 4, gb outputs 0.
- Simultaneous dec_req and gb_req after reset, len=2 each -> DEC served first, then GB; the next tie grants DEC again (alternation); one idle cycle between bursts.
- mem_ack and first mem_data_valid in the same cycle, len=1 -> dec_done the next cycle, state back to IDLE.
- burst_len=0 on gb -> exactly 64 gb_data_valid pulses before gb_done.
- Stray mem_data_valid in IDLE -> proto_err=1, held until rst, no *_data_valid.
- rst asserted mid-XFER (after beat 2 of 8) -> all outputs 0 immediately; the next request restarts cleanly with DEC priority.
